cyq_tt_scan_ctrl: RTL and testbench

//  Sequencer that exercises a 3-input combinational function block (74HC153-style mux function generator).

---
 rtl/cyq_scan_pkg.sv | 21 ++
 rtl/cyq_sync2.sv | 22 ++
 rtl/cyq_tt_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_cyq_tt_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cyq_scan_pkg.sv
// Shared types and constants for the truth-table scan controller.
// State codes are exported as ST_* so other code can name them.
package cyq_scan_pkg;

  localparam int SETTLE_MIN = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/cyq_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Synchronous active-low reset clears both stages to 0.
module cyq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cyq_tt_scan_ctrl.sv
// Walks a combinational block through every input code and captures its truth table.
// Optional result compare (exp_tt/match/err_mask) is built when CYQ_SCAN_CMP_EN is defined.
module cyq_tt_scan_ctrl
  import cyq_scan_pkg::*;
#(
  parameter  int N_IN       = 3,
  parameter  int SETTLE_CYC = 4,
  localparam int TT_W       = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_y,
  output logic [N_IN-1:0] drv_abc,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt
`ifdef CYQ_SCAN_CMP_EN
  ,
  input  logic [TT_W-1:0] exp_tt,
  output logic            match,
  output logic [TT_W-1:0] err_mask
`endif
);

  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(TT_W - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < SETTLE_MIN) begin : g_bad_settle
    $error("SETTLE_CYC below synchronizer latency");
  end

  state_e          state, state_n;
  logic [N_IN:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_IN-1:0] drv_n;
  logic [TT_W-1:0] tt_n;
  logic            busy_n;
  logic            done_n;
  logic            y_s;
  logic            accept;
  logic            finish;

  cyq_sync2 u_sync_y (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_y),
    .q     (y_s)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    drv_n   = drv_abc;
    tt_n    = tt;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_n = S_DRIVE;
          idx_n   = '0;
          tt_n    = '0;
        end
      end
      S_DRIVE: begin
        drv_n   = idx[N_IN-1:0];
        cnt_n   = '0;
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_n = S_SAMPLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        tt_n[idx[N_IN-1:0]] = y_s;
        if (idx == IDX_LAST) begin
          state_n = S_DONE;
          finish  = 1'b1;
        end else begin
          idx_n   = idx + (N_IN+1)'(1);
          state_n = S_DRIVE;
        end
      end
      S_DONE: begin
        drv_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    // Abort drops the scan but leaves the partial table visible.
    if (abort && (state inside {S_DRIVE, S_SETTLE, S_SAMPLE})) begin
      state_n = S_IDLE;
      drv_n   = '0;
      idx_n   = '0;
      cnt_n   = cnt;
      tt_n    = tt;
      finish  = 1'b0;
    end
    busy_n = state_n inside {S_DRIVE, S_SETTLE, S_SAMPLE};
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      drv_abc <= '0;
      tt      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      drv_abc <= drv_n;
      tt      <= tt_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

`ifdef CYQ_SCAN_CMP_EN
  // Compare against the table as it completes so the result lines up with done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match    <= 1'b0;
      err_mask <= '0;
    end else if (accept) begin
      match    <= 1'b0;
      err_mask <= '0;
    end else if (finish) begin
      match    <= (tt_n == exp_tt);
      err_mask <= tt_n ^ exp_tt;
    end
  end
`else
  // Result compare not built.
`endif

endmodule

// File: tb/tb_cyq_tt_scan_ctrl.sv
// Self-checking bench: random function tables scanned and compared with a timing model.
// Build with CYQ_SCAN_CMP_EN to also exercise exp_tt/match/err_mask.
module tb_cyq_tt_scan_ctrl;

  localparam int N_IN       = 3;
  localparam int SETTLE_CYC = 4;
  localparam int TT_W       = 8;
  localparam int VEC_CYC    = SETTLE_CYC + 2;
  localparam int SCAN_CYC   = TT_W * VEC_CYC;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            dut_y = 1'b0;
  logic [N_IN-1:0] drv_abc;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt;
`ifdef CYQ_SCAN_CMP_EN
  logic [TT_W-1:0] exp_tt = '0;
  logic            match;
  logic [TT_W-1:0] err_mask;
`endif

  logic [TT_W-1:0] func = '0;
  logic [TT_W-1:0] par;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Function block model: Y follows the drive one clock later.
  always @(posedge clk) dut_y <= func[drv_abc];

  cyq_tt_scan_ctrl #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .dut_y    (dut_y),
    .drv_abc  (drv_abc),
    .busy     (busy),
    .done     (done),
    .tt       (tt)
`ifdef CYQ_SCAN_CMP_EN
    ,
    .exp_tt   (exp_tt),
    .match    (match),
    .err_mask (err_mask)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [TT_W-1:0] t_exp);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_drv", drv_abc, 0);
    check("idle_tt", tt, t_exp);
  endtask

  task automatic run_scan(input logic [TT_W-1:0] f,
                          input logic [TT_W-1:0] xp,
                          input bit repulse);
    func = f;
`ifdef CYQ_SCAN_CMP_EN
    exp_tt = xp;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start", busy, 1);
    check("tt_clr", tt, 0);
    for (int k = 1; k <= SCAN_CYC + 1; k++) begin
      if (repulse && (k == 10 || k == SCAN_CYC + 1)) start = 1'b1;
      step();
      start = 1'b0;
      check("done", done, 32'(k == SCAN_CYC));
      check("busy", busy, 32'(k < SCAN_CYC));
      check("drv", drv_abc,
            (k <= SCAN_CYC) ? (k - 1) / VEC_CYC : 0);
      if (k == SCAN_CYC) begin
        check("tt", tt, f);
`ifdef CYQ_SCAN_CMP_EN
        check("match", match, 32'(f == xp));
        check("err_mask", err_mask, f ^ xp);
`endif
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle(f);
`ifdef CYQ_SCAN_CMP_EN
      check("match_hold", match, 32'(f == xp));
      check("err_hold", err_mask, f ^ xp);
`endif
    end
  endtask

  initial begin
    logic [TT_W-1:0] r;
    logic [TT_W-1:0] part;
    int seen;

    for (int i = 0; i < TT_W; i++) begin
      logic [N_IN-1:0] code;
      code = N_IN'(i);
      par[i] = ^code;
    end
    check("parity_ref", par, 8'h96);

    rst_n = 1'b0;
    step();
    step();
    check_idle(0);
    rst_n = 1'b1;
    step();
    check_idle(0);

    run_scan(par, 8'h96, 1'b0);
    run_scan(8'hFF, 8'hFF, 1'b0);
    run_scan(8'h00, 8'h00, 1'b0);

    run_scan(par, 8'h96, 1'b1);
    step();
    check_idle(par);

    // abort and start together in IDLE: stay idle
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle(par);

    // abort mid-scan, sampled at edge t+20
    func = par;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 20; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_drv", drv_abc, 0);
    part = '0;
    for (int i = 0; i < TT_W; i++)
      if ((i + 1) * VEC_CYC < 20) part[i] = par[i];
    check("abort_tt", tt, part);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done || busy) seen++;
    end
    check("abort_quiet", seen, 0);
    run_scan(par, 8'h97, 1'b0);

    // reset mid-scan at edge t+30
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 30; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle(0);
`ifdef CYQ_SCAN_CMP_EN
    check("rst_match", match, 0);
    check("rst_err", err_mask, 0);
`endif
    step();
    check_idle(0);

    for (int n = 0; n < 5; n++) begin
      r = TT_W'($urandom);
      repeat ($urandom_range(0, 4)) step();
      if (n[0])
        run_scan(r, r, 1'b0);
      else
        run_scan(r, r ^ (TT_W'(1) << $urandom_range(0, TT_W - 1)),
                 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
